// File: rtl/wb_regfile_pkg.sv
// Shared defines for the write-back stage: control encodings, bus widths
// and the NOP constants used by the MEM/WB latch and the register array.
package wb_regfile_pkg;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

endpackage

// File: rtl/wb_regfile_mem_wb.sv
// MEM/WB pipeline latch: captures the MEM-stage result, holds it on stall
// and collapses to a NOP on flush (flush wins over stall).
module mem_wb
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata
);

    // Latch update: reset and flush load a NOP, stall holds, otherwise capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            wb_wd    <= ADDR_W'(NOPRegAddr);
            wb_wreg  <= WriteDisable;
            wb_wdata <= DATA_W'(ZeroWord);
        end else if (flush) begin
            wb_wd    <= ADDR_W'(NOPRegAddr);
            wb_wreg  <= WriteDisable;
            wb_wdata <= DATA_W'(ZeroWord);
        end else if (!stall) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB latch plus a 2-read / 1-write register array.
// Register 0 is hard-wired to zero. Defining WB_REGFILE_BYPASS_EN forwards
// the in-flight write-back value to a read port addressing the same entry;
// without it, reads see array contents only and the ID stage forwards.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam int                NREG   = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] ZERO_D = DATA_W'(ZeroWord);
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(NOPRegAddr);

    logic [DATA_W-1:0] regs [NREG];

    mem_wb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_wb (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata)
    );

    // Array read with port enable and the register-0 zero rule.
    function automatic logic [DATA_W-1:0] array_read(
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic [DATA_W-1:0] entry
    );
        if (re == ReadDisable || raddr == ZERO_A)
            return ZERO_D;
        return entry;
    endfunction

`ifdef WB_REGFILE_BYPASS_EN
    // True when a read port targets the entry being written this cycle.
    function automatic logic bypass_hit(
        input logic              re,
        input logic [ADDR_W-1:0] raddr
    );
        return (re == ReadEnable) && (wb_wreg == WriteEnable) &&
               (raddr == wb_wd) && (raddr != ZERO_A);
    endfunction
`endif

    // Array write from the latch; reset clears every entry at once, so a
    // write-back interrupted by reset never lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= ZERO_D;
        end else if (wb_wreg == WriteEnable && wb_wd != ZERO_A) begin
            regs[wb_wd] <= wb_wdata;
        end
    end

    // Combinational read ports, forced to zero while reset is asserted.
    always_comb begin
        rdata1 = array_read(re1, raddr1, regs[raddr1]);
        rdata2 = array_read(re2, raddr2, regs[raddr2]);
`ifdef WB_REGFILE_BYPASS_EN
        if (bypass_hit(re1, raddr1))
            rdata1 = wb_wdata;
        if (bypass_hit(re2, raddr2))
            rdata2 = wb_wdata;
`endif
        if (rst == RstEnable) begin
            rdata1 = ZERO_D;
            rdata2 = ZERO_D;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile: latch capture/stall/flush, array
// write latency, register-0 handling, read enables and async reset.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata),
        .re1       (re1),
        .raddr1    (raddr1),
        .rdata1    (rdata1),
        .re2       (re2),
        .raddr2    (raddr2),
        .rdata2    (rdata2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd1(input logic [4:0] a);
        re1 = 1'b1;
        raddr1 = a;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0;
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;
        #1;
        // Reset state
        chk("rst_wb_wd", 64'(wb_wd), 64'd0);
        chk("rst_wb_wreg", 64'(wb_wreg), 64'd0);
        chk("rst_wb_wdata", 64'(wb_wdata), 64'd0);
        chk("rst_rdata1", 64'(rdata1), 64'd0);
        chk("rst_rdata2", 64'(rdata2), 64'd0);
        tick();
        rst = 1'b0;

        // Basic write: latch after edge 0, array after edge 1
        mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'hDEADBEEF;
        raddr1 = 5'd5;
        tick();
        chk("lat_wd", 64'(wb_wd), 64'd5);
        chk("lat_wreg", 64'(wb_wreg), 64'd1);
        chk("lat_wdata", 64'(wb_wdata), 64'hDEADBEEF);
`ifdef WB_REGFILE_BYPASS_EN
        chk("wcycle_read", 64'(rdata1), 64'hDEADBEEF);
`else
        chk("wcycle_read", 64'(rdata1), 64'd0);
`endif
        mem_wreg = 1'b0;
        tick();
        chk("after_write_read", 64'(rdata1), 64'hDEADBEEF);

        // Register 0 discards writes
        mem_wd = 5'd0; mem_wreg = 1'b1; mem_wdata = 32'h12345678;
        tick();
        chk("r0_lat_wdata", 64'(wb_wdata), 64'h12345678);
        mem_wreg = 1'b0;
        tick();
        rd1(5'd0);
        re2 = 1'b1; raddr2 = 5'd0; #1;
        chk("r0_read1", 64'(rdata1), 64'd0);
        chk("r0_read2", 64'(rdata2), 64'd0);

        // Read enable on port 2, and both ports on one address
        mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'hA5A5A5A5;
        tick();
        mem_wreg = 1'b0;
        tick();
        re2 = 1'b0; raddr2 = 5'd9; #1;
        chk("re2_off", 64'(rdata2), 64'd0);
        re2 = 1'b1; #1;
        chk("re2_on", 64'(rdata2), 64'hA5A5A5A5);
        rd1(5'd9);
        chk("dual_same", 64'(rdata1), 64'(rdata2));
        chk("dual_val1", 64'(rdata1), 64'hA5A5A5A5);

        // Stall holds the latch for 3 cycles while MEM inputs change
        mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h11;
        tick();
        stall = 1'b1;
        mem_wd = 5'd8;  mem_wdata = 32'h22; tick();
        chk("stall1_wd", 64'(wb_wd), 64'd7);
        chk("stall1_data", 64'(wb_wdata), 64'h11);
        mem_wd = 5'd10; mem_wdata = 32'h33; tick();
        chk("stall2_wd", 64'(wb_wd), 64'd7);
        mem_wd = 5'd11; mem_wdata = 32'h44; tick();
        chk("stall3_wd", 64'(wb_wd), 64'd7);
        chk("stall3_data", 64'(wb_wdata), 64'h11);
        stall = 1'b0; mem_wreg = 1'b0;
        tick();
        tick();
        rd1(5'd7);  chk("stall_r7", 64'(rdata1), 64'h11);
        rd1(5'd8);  chk("stall_r8", 64'(rdata1), 64'd0);
        rd1(5'd10); chk("stall_r10", 64'(rdata1), 64'd0);
        rd1(5'd11); chk("stall_r11", 64'(rdata1), 64'd0);

        // Back-to-back writes to one entry: last write wins
        mem_wd = 5'd12; mem_wreg = 1'b1; mem_wdata = 32'h100;
        tick();
        mem_wdata = 32'h200;
        tick();
        rd1(5'd12);
`ifdef WB_REGFILE_BYPASS_EN
        chk("lww_mid", 64'(rdata1), 64'h200);
`else
        chk("lww_mid", 64'(rdata1), 64'h100);
`endif
        mem_wreg = 1'b0;
        tick();
        chk("lww_final", 64'(rdata1), 64'h200);

        // Flush beats stall; NOP produces no array write
        mem_wd = 5'd13; mem_wreg = 1'b1; mem_wdata = 32'h55;
        tick();
        stall = 1'b1; flush = 1'b1;
        mem_wd = 5'd14; mem_wdata = 32'h66;
        tick();
        chk("flush_wd", 64'(wb_wd), 64'd0);
        chk("flush_wreg", 64'(wb_wreg), 64'd0);
        chk("flush_wdata", 64'(wb_wdata), 64'd0);
        flush = 1'b0;
        tick();
        chk("flush_hold_wreg", 64'(wb_wreg), 64'd0);
        stall = 1'b0; mem_wreg = 1'b0;
        tick();
        rd1(5'd13); chk("flush_r13", 64'(rdata1), 64'h55);
        rd1(5'd14); chk("flush_r14", 64'(rdata1), 64'd0);

        // Fill registers 1..31, then reset mid-run
        for (int i = 1; i < 32; i++) begin
            mem_wd = 5'(i); mem_wreg = 1'b1; mem_wdata = 32'h01010101 * 32'(i);
            tick();
        end
        mem_wreg = 1'b0;
        tick();
        tick();
        rd1(5'd1);  chk("fill_r1", 64'(rdata1), 64'h01010101);
        rd1(5'd16); chk("fill_r16", 64'(rdata1), 64'h10101010);
        rd1(5'd31); chk("fill_r31", 64'(rdata1), 64'h1F1F1F1F);
        mem_wd = 5'd20; mem_wreg = 1'b1; mem_wdata = 32'hFFFF0000;
        raddr1 = 5'd20;
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_wb_wd", 64'(wb_wd), 64'd0);
        chk("arst_wb_wreg", 64'(wb_wreg), 64'd0);
        chk("arst_wb_wdata", 64'(wb_wdata), 64'd0);
        chk("arst_rdata1", 64'(rdata1), 64'd0);
        mem_wreg = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd1(5'(i));
            chk($sformatf("post_rst_r%0d", i), 64'(rdata1), 64'd0);
        end

        // First capture after reset release happens on the first edge
        mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h77;
        tick();
        chk("rel_wd", 64'(wb_wd), 64'd3);
        chk("rel_wdata", 64'(wb_wdata), 64'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
